// File: rtl/data_break_requester_pkg.sv
// Shared types for the RK8E data-break requester: word type, FSM state codes, word helpers.
package data_break_requester_pkg;

    localparam int WORD_W = 12;

    typedef logic [0:WORD_W-1] word_t;

    // Requester state codes; kept apart from the CPU's DB0/DB1 break states.
    typedef enum logic [2:0] {
        DBR_IDLE,
        DBR_WAIT,
        DBR_REQ,
        DBR_BRK,
        DBR_POST,
        DBR_DONE
    } dbr_state_e;

    // Plain 12-bit increment; wraps 7777 -> 0000 and never carries into the field.
    function automatic word_t word_inc(input word_t w);
        return w + word_t'(1);
    endfunction

endpackage

// File: rtl/data_break_requester_if.sv
// Data-break bus between a device-side requester (master) and the CPU state machine (slave).
interface data_break_requester_if #(
    parameter int FIELD_W = 3
);
    import data_break_requester_pkg::*;

    logic               data_break;
    logic               to_disk;
    word_t              db_addr;
    logic [FIELD_W-1:0] db_field;
    word_t              db_wr_data;
    logic               break_in_prog;
    word_t              mem_rd_data;

    modport master (
        output data_break, to_disk, db_addr, db_field, db_wr_data,
        input  break_in_prog, mem_rd_data
    );

    modport slave (
        input  data_break, to_disk, db_addr, db_field, db_wr_data,
        output break_in_prog, mem_rd_data
    );

endinterface

// File: rtl/data_break_requester.sv
// RK8E data-break initiator: requests one CPU break per word and moves that word
// between the memory bus and the disk word stream until the word count reaches zero.
module data_break_requester
    import data_break_requester_pkg::*;
#(
    parameter int FIELD_W     = 3,
    parameter int REQ_TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       dir_to_disk,
    input  word_t                      start_addr,
    input  logic [FIELD_W-1:0]         start_field,
    input  word_t                      wc_init,
    input  logic                       abort,
    input  logic                       dev_rx_valid,
    input  word_t                      dev_rx_data,
    output logic                       dev_rx_ready,
    input  logic                       dev_tx_ready,
    output logic                       dev_tx_valid,
    output word_t                      dev_tx_data,
    data_break_requester_if.master     db,
    output word_t                      cur_addr,
    output word_t                      cur_wc,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CNT_W = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;

    dbr_state_e         state, state_d;
    logic               dir_q, bip_q, abort_seen;
    logic               data_break_q, to_disk_q;
    logic [FIELD_W-1:0] field_q;
    word_t              addr_q, wc_q, wr_data_q, rd_data_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               bip_rise, wc_last, tmo_hit, rx_take, post_go;

    assign bip_rise = db.break_in_prog & ~bip_q;
    assign wc_last  = (word_inc(wc_q) == '0);
    assign tmo_hit  = (REQ_TIMEOUT != 0) && !db.break_in_prog &&
                      (tmo_cnt == CNT_W'(REQ_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= DBR_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        rx_take = 1'b0;
        post_go = 1'b0;
        case (state)
            DBR_IDLE: if (start && !abort) state_d = DBR_WAIT;
            DBR_WAIT: begin
                if (abort) begin
                    state_d = DBR_DONE;
                end else if (dir_q) begin
                    state_d = DBR_REQ;
                end else if (dev_rx_valid) begin
                    rx_take = 1'b1;
                    state_d = DBR_REQ;
                end
            end
            DBR_REQ: begin
                if (bip_rise)     state_d = DBR_BRK;
                else if (tmo_hit) state_d = DBR_DONE;
            end
            DBR_BRK: if (!db.break_in_prog) state_d = DBR_POST;
            // A memory->disk word leaves only once the disk side can take it.
            DBR_POST: begin
                if (!dir_q || dev_tx_ready) begin
                    post_go = 1'b1;
                    state_d = (wc_last || abort_seen || abort) ? DBR_DONE : DBR_WAIT;
                end
            end
            DBR_DONE: state_d = DBR_IDLE;
            default:  state_d = DBR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q        <= 1'b0;
            bip_q        <= 1'b0;
            abort_seen   <= 1'b0;
            data_break_q <= 1'b0;
            to_disk_q    <= 1'b0;
            field_q      <= '0;
            addr_q       <= '0;
            wc_q         <= '0;
            wr_data_q    <= '0;
            rd_data_q    <= '0;
            tmo_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bip_q <= db.break_in_prog;
            if (state == DBR_IDLE && state_d == DBR_WAIT) begin
                dir_q      <= dir_to_disk;
                addr_q     <= start_addr;
                field_q    <= start_field;
                wc_q       <= wc_init;
                busy       <= 1'b1;
                err        <= 1'b0;
                abort_seen <= 1'b0;
            end
            // Abort during a committed break is remembered and honoured after POST.
            if (state != DBR_IDLE && abort) abort_seen <= 1'b1;
            if (rx_take) wr_data_q <= dev_rx_data;

            if (state != DBR_REQ && state_d == DBR_REQ) begin
                data_break_q <= 1'b1;
                to_disk_q    <= dir_q;
                tmo_cnt      <= '0;
            end else if (state == DBR_REQ) begin
                if (state_d != DBR_REQ) begin
                    data_break_q <= 1'b0;
                    to_disk_q    <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end

            // Memory data is valid in the final break_in_prog cycle, so the last capture wins.
            if ((state == DBR_REQ || state == DBR_BRK) && db.break_in_prog)
                rd_data_q <= db.mem_rd_data;

            if (post_go) begin
                addr_q <= word_inc(addr_q);
                wc_q   <= word_inc(wc_q);
            end

            if (state != DBR_DONE && state_d == DBR_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (state == DBR_REQ) err <= 1'b1;
            end else begin
                done <= 1'b0;
            end
        end
    end

    assign dev_rx_ready  = rx_take;
    assign dev_tx_valid  = post_go & dir_q;
    assign dev_tx_data   = rd_data_q;
    assign db.data_break = data_break_q;
    assign db.to_disk    = to_disk_q;
    assign db.db_addr    = addr_q;
    assign db.db_field   = field_q;
    assign db.db_wr_data = wr_data_q;
    assign cur_addr      = addr_q;
    assign cur_wc        = wc_q;

endmodule

// File: tb/tb_data_break_requester.sv
// Bench for data_break_requester: CPU break model, disk rx/tx models and a scoreboard of
// expected breaks and transmitted words, driven from a transfer table plus corner sequences.
module tb_data_break_requester;
    import data_break_requester_pkg::*;

    localparam int FW  = 3;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, dir_to_disk = 1'b0, abort = 1'b0;
    logic          dev_rx_valid = 1'b0, dev_tx_ready = 1'b0;
    word_t         start_addr = '0, wc_init = '0, dev_rx_data = '0;
    logic [FW-1:0] start_field = '0;
    logic          dev_rx_ready, dev_tx_valid, busy, done, err;
    word_t         dev_tx_data, cur_addr, cur_wc;

    data_break_requester_if #(.FIELD_W(FW)) dif();

    data_break_requester #(.FIELD_W(FW), .REQ_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .dir_to_disk(dir_to_disk),
        .start_addr(start_addr), .start_field(start_field), .wc_init(wc_init), .abort(abort),
        .dev_rx_valid(dev_rx_valid), .dev_rx_data(dev_rx_data), .dev_rx_ready(dev_rx_ready),
        .dev_tx_ready(dev_tx_ready), .dev_tx_valid(dev_tx_valid), .dev_tx_data(dev_tx_data),
        .db(dif.master), .cur_addr(cur_addr), .cur_wc(cur_wc),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        word_t         addr;
        logic [FW-1:0] field;
        logic          to_disk;
        word_t         wdata;
    } brk_t;

    typedef struct {
        logic          dir;
        word_t         addr;
        logic [FW-1:0] field;
        word_t         wc;
        int            n;
        word_t         w0, w1, w2;
        word_t         exp_addr;
    } vec_t;

    brk_t  brk_q[$];
    word_t tx_q[$];
    word_t rx_q[$];
    word_t mem [0:32767];
    logic  cpu_halt = 1'b0;
    logic  rx_en = 1'b1;
    vec_t  vecs [5];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0o required=%0o", name, act, exp);
        end
    endtask

    // CPU break service: answers a request on its 3rd cycle with a two-cycle DB0/DB1 window.
    initial begin : cpu_model
        int   cnt;
        int   phase;
        brk_t e;
        cnt = 0;
        phase = 0;
        dif.break_in_prog = 1'b0;
        dif.mem_rd_data = '0;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (!reset) begin
                cnt = 0;
                phase = 0;
                dif.break_in_prog = 1'b0;
                dif.mem_rd_data = '0;
            end else if (phase == 1) begin
                phase = 2;
                dif.mem_rd_data = mem[{dif.db_field, dif.db_addr}];
                chk("db_dropped_in_db1", 32'(dif.data_break), 0);
            end else if (phase == 2) begin
                phase = 0;
                cnt = 0;
                dif.break_in_prog = 1'b0;
                dif.mem_rd_data = '0;
            end else if (dif.data_break && !cpu_halt) begin
                cnt++;
                if (cnt == 3) begin
                    phase = 1;
                    dif.break_in_prog = 1'b1;
                    dif.mem_rd_data = ~mem[{dif.db_field, dif.db_addr}];
                    chk("break_expected", 32'(brk_q.size() > 0), 1);
                    if (brk_q.size() > 0) begin
                        e = brk_q.pop_front();
                        chk("brk_addr", 32'(dif.db_addr), 32'(e.addr));
                        chk("brk_field", 32'(dif.db_field), 32'(e.field));
                        chk("brk_to_disk", 32'(dif.to_disk), 32'(e.to_disk));
                        if (!e.to_disk) chk("brk_wr_data", 32'(dif.db_wr_data), 32'(e.wdata));
                    end
                end
            end
        end
    end

    initial begin : dev_drv
        forever begin
            @(posedge clk);
            #1;
            dev_rx_valid = rx_en && (rx_q.size() > 0);
            dev_rx_data  = (rx_q.size() > 0) ? rx_q[0] : '0;
            dev_tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        int    ovl;
        word_t w;
        ovl = 0;
        forever begin
            @(negedge clk);
            if (dev_rx_ready) begin
                chk("rx_ready_needs_valid", 32'(dev_rx_valid), 1);
                if (rx_q.size() > 0) w = rx_q.pop_front();
            end
            if (dev_tx_valid) begin
                chk("tx_valid_needs_ready", 32'(dev_tx_ready), 1);
                chk("tx_expected", 32'(tx_q.size() > 0), 1);
                if (tx_q.size() > 0) begin
                    w = tx_q.pop_front();
                    chk("tx_data", 32'(dev_tx_data), 32'(w));
                end
            end
            if (dif.data_break && dif.break_in_prog) begin
                ovl++;
                chk("db_bip_overlap", 32'(ovl), 1);
            end else begin
                ovl = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic d, input word_t a, input logic [FW-1:0] f, input word_t wc);
        dir_to_disk = d;
        start_addr  = a;
        start_field = f;
        wc_init     = wc;
        start       = 1'b1;
        cyc(1);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_busy_at_done"}, 32'(busy), 0);
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 32'(done), 0);
        end
        cyc(1);
    endtask

    task automatic count_db(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dif.data_break) hi++;
        end
        cyc(1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        word_t w [3];
        word_t a;
        brk_t  r;
        w[0] = v.w0;
        w[1] = v.w1;
        w[2] = v.w2;
        for (int k = 0; k < v.n; k++) begin
            a         = v.addr + word_t'(k);
            r.addr    = a;
            r.field   = v.field;
            r.to_disk = v.dir;
            r.wdata   = w[k];
            brk_q.push_back(r);
            if (v.dir) begin
                mem[{v.field, a}] = w[k];
                tx_q.push_back(w[k]);
            end else begin
                rx_q.push_back(w[k]);
            end
        end
        start_pulse(v.dir, v.addr, v.field, v.wc);
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_done(400, tag);
        chk({tag, "_cur_addr"}, 32'(cur_addr), 32'(v.exp_addr));
        chk({tag, "_cur_wc"}, 32'(cur_wc), 0);
        chk({tag, "_field_kept"}, 32'(dif.db_field), 32'(v.field));
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_breaks_left"}, 32'(brk_q.size()), 0);
        chk({tag, "_tx_left"}, 32'(tx_q.size()), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "bench time limit");
    end

    initial begin : main
        int    hi;
        bit    seen;
        brk_t  r;

        for (int i = 0; i < 32768; i++) mem[i] = word_t'(i * 5 + 1);

        //            dir   addr      field  wc       n  w0        w1        w2        exp_addr
        vecs[0] = '{1'b0, 12'o0200, 3'd1, 12'o7775, 3, 12'o1111, 12'o2222, 12'o3333, 12'o0203};
        vecs[1] = '{1'b1, 12'o7776, 3'd2, 12'o7776, 2, 12'o4321, 12'o1234, 12'o0000, 12'o0000};
        vecs[2] = '{1'b0, 12'o7777, 3'd7, 12'o7777, 1, 12'o0707, 12'o0000, 12'o0000, 12'o0000};
        vecs[3] = '{1'b1, 12'o0000, 3'd0, 12'o7775, 3, 12'o7777, 12'o0001, 12'o5252, 12'o0003};
        vecs[4] = '{1'b0, 12'o1234, 3'd3, 12'o7776, 2, 12'o0000, 12'o7777, 12'o0000, 12'o1236};

        cyc(3);
        @(negedge clk);
        chk("rst_data_break", 32'(dif.data_break), 0);
        chk("rst_to_disk", 32'(dif.to_disk), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rx_ready", 32'(dev_rx_ready), 0);
        chk("rst_tx_valid", 32'(dev_tx_valid), 0);
        chk("rst_cur_addr", 32'(cur_addr), 0);
        chk("rst_cur_wc", 32'(cur_wc), 0);
        chk("rst_wr_data", 32'(dif.db_wr_data), 0);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // CPU never answers: request must time out after TMO cycles.
        cpu_halt = 1'b1;
        start_pulse(1'b1, 12'o0100, 3'd5, 12'o7777);
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (dif.data_break) hi++;
            if (done) seen = 1'b1;
        end
        chk("tmo_done_seen", 32'(seen), 1);
        chk("tmo_db_cycles", 32'(hi), 32'(TMO));
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_wc_kept", 32'(cur_wc), 32'(12'o7777));
        cpu_halt = 1'b0;
        cyc(2);

        // Abort during the first break of four.
        r.addr = 12'o0400; r.field = 3'd0; r.to_disk = 1'b0; r.wdata = 12'o0101;
        brk_q.push_back(r);
        rx_q.push_back(12'o0101);
        rx_q.push_back(12'o0202);
        rx_q.push_back(12'o0303);
        rx_q.push_back(12'o0404);
        start_pulse(1'b0, 12'o0400, 3'd0, 12'o7774);
        chk("abt_err_cleared", 32'(err), 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (dif.break_in_prog) seen = 1'b1;
        end
        chk("abt_break_seen", 32'(seen), 1);
        cyc(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        wait_done(100, "abt");
        chk("abt_cur_wc", 32'(cur_wc), 32'(12'o7775));
        chk("abt_cur_addr", 32'(cur_addr), 32'(12'o0401));
        count_db(10, hi);
        chk("abt_no_more_breaks", 32'(hi), 0);
        chk("abt_rx_left", 32'(rx_q.size()), 3);
        rx_q.delete();

        // Reset while a request is outstanding.
        start_pulse(1'b1, 12'o0500, 3'd2, 12'o7776);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dif.data_break) seen = 1'b1;
        end
        chk("rstmid_req_seen", 32'(seen), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_data_break", 32'(dif.data_break), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_cur_wc", 32'(cur_wc), 0);
        chk("rstmid_to_disk", 32'(dif.to_disk), 0);
        @(negedge clk);
        reset = 1'b1;
        brk_q.delete();
        tx_q.delete();
        cyc(2);
        run_vec(vecs[0], "post_reset");

        // Second start while busy is ignored; no request until the rx word arrives.
        r.addr = 12'o0600; r.field = 3'd4; r.to_disk = 1'b0; r.wdata = 12'o5555;
        brk_q.push_back(r);
        start_pulse(1'b0, 12'o0600, 3'd4, 12'o7777);
        cyc(5);
        start_pulse(1'b1, 12'o1000, 3'd6, 12'o7770);
        count_db(20, hi);
        chk("busy2_no_request", 32'(hi), 0);
        chk("busy2_busy", 32'(busy), 1);
        rx_q.push_back(12'o5555);
        wait_done(100, "busy2");
        chk("busy2_cur_addr", 32'(cur_addr), 32'(12'o0601));
        chk("busy2_cur_wc", 32'(cur_wc), 0);
        chk("busy2_field", 32'(dif.db_field), 4);
        chk("busy2_breaks_left", 32'(brk_q.size()), 0);

        // start together with abort in IDLE stays idle.
        start_addr = 12'o1111;
        wc_init    = 12'o7770;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("stabt_busy", 32'(busy), 0);
        chk("stabt_cur_addr", 32'(cur_addr), 32'(12'o0601));
        count_db(5, hi);
        chk("stabt_no_request", 32'(hi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
